seq_div32: RTL

//  Iterative restoring divider; consumer and driver of the 32-bit subtractor stage.

---
 rtl/seq_div32_if.sv | 26 ++
 rtl/seq_div32.sv | 104 ++++++++++
 2 files changed

// File: rtl/seq_div32_if.sv
// Request/result bundle for the sequential divider: operands in, quotient/remainder out.
// Each side has its own valid/ready pair; the divider is the slave.
interface seq_div32_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, is_signed, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, is_signed, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_div32.sv
// Restoring divider, one trial subtraction per clock; result WIDTH clocks after accept, next clock on /0.
// Result is held in DONE until out_ready; no new request is taken until the result drains.
module seq_div32 #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  seq_div32_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dmag;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] amag;
  logic [WIDTH-1:0] bmag;
  logic [WIDTH:0]   t;
  logic             borrow;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_next;

  always_comb begin
    amag   = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    bmag   = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
    // R never exceeds the divisor magnitude, so only its low WIDTH bits need storing.
    t      = {r, q[WIDTH-1]} - {1'b0, dmag};
    borrow = t[WIDTH];
    q_next = {q[WIDTH-2:0], ~borrow};
    r_next = borrow ? {r[WIDTH-2:0], q[WIDTH-1]} : t[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      count           <= '0;
      r               <= '0;
      q               <= '0;
      dmag            <= '0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      bus.in_ready    <= 1'b1;
      bus.out_valid   <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bus.in_ready <= 1'b0;
            if (bus.divisor == '0) begin
              state           <= DONE;
              bus.out_valid   <= 1'b1;
              bus.quotient    <= '1;
              bus.remainder   <= bus.dividend;
              bus.div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
              neg_q <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
              neg_r <= bus.is_signed & bus.dividend[WIDTH-1];
              q     <= amag;
              dmag  <= bmag;
              r     <= '0;
              count <= '0;
            end
          end
        end
        CALC: begin
          q     <= q_next;
          r     <= r_next;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state           <= DONE;
            bus.out_valid   <= 1'b1;
            bus.quotient    <= neg_q ? -q_next : q_next;
            bus.remainder   <= neg_r ? -r_next : r_next;
            bus.div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
